// File: rtl/sha_pkg.sv
// Shared SHA-256 types, padding constants and the message padder state encoding.
package sha_pkg;

   typedef logic [31:0]       sha_word_t;
   typedef logic [0:15][31:0] sha_block_t;

   localparam logic [7:0] SHA_PAD_BYTE = 8'h80;
   localparam sha_word_t  SHA_PAD_WORD = {SHA_PAD_BYTE, 24'h000000};

   typedef enum logic [1:0] {
      S_FILL,
      S_PAD,
      S_EMIT,
      S_TAIL
   } pad_state_t;

   // Byte counts above 4 on a final word are treated as a full word.
   function automatic logic [2:0] clamp_nbytes(input logic [2:0] n);
      return (n > 3'd4) ? 3'd4 : n;
   endfunction

endpackage

// File: rtl/sha_last_word_mask.sv
// Keeps the valid leading bytes of a final message word and inserts the 0x80 pad byte after them.
// carry is raised when the word is full, meaning the pad byte belongs in the following word.
module sha_last_word_mask
   import sha_pkg::*;
(
   input  sha_word_t  data,
   input  logic [2:0] nbytes,
   output sha_word_t  masked,
   output logic       carry
);

   logic [2:0] n;

   assign n     = clamp_nbytes(nbytes);
   assign carry = (n == 3'd4);

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_byte
         assign masked[31-8*gi -: 8] = (3'(gi) < n)  ? data[31-8*gi -: 8] :
                                       (3'(gi) == n) ? SHA_PAD_BYTE : 8'h00;
      end
   endgenerate

endmodule

// File: rtl/sha_msg_padder.sv
// SHA-256 message padder: 32-bit big-endian word stream in, padded 512-bit blocks out.
// Defining SHA_MSG_PADDER_ERRCHK_EN adds a sticky err output for final words with in_nbytes > 4.
module sha_msg_padder
   import sha_pkg::*;
#(
   parameter int LEN_W = 64
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       in_valid,
   output logic       in_ready,
   input  sha_word_t  in_data,
   input  logic       in_last,
   input  logic [2:0] in_nbytes,
   output logic       blk_valid,
   input  logic       blk_ready,
   output sha_block_t blk_data,
   output logic       blk_first,
`ifdef SHA_MSG_PADDER_ERRCHK_EN
   output logic       err,
`endif
   output logic       blk_last
);

   pad_state_t       state_reg, state_next;
   sha_block_t       blk_reg;
   logic [3:0]       widx_reg;
   logic [LEN_W-1:0] len_reg;
   logic [2:0]       nbytes_reg;
   logic             first_reg;
   logic             last_reg;
   logic             tail_reg;
   logic             pend_reg;

   logic             accept;
   logic [5:0]       add_bits;
   logic [63:0]      len64;
   logic [0:1][31:0] len_words;
   sha_word_t        mask_word;
   logic             mask_carry;
   logic [4:0]       widx_ext;
   logic [4:0]       pad_pos;
   logic             len_fits;
   sha_block_t       pad_block;
   sha_block_t       tail_block;

   // ---------------- control FSM ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= S_FILL;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      in_ready   = 1'b0;
      blk_valid  = 1'b0;
      case (state_reg)
         S_FILL: begin
            in_ready = 1'b1;
            if (in_valid) begin
               if (in_last) begin
                  state_next = S_PAD;
               end else if (widx_reg == 4'd15) begin
                  state_next = S_EMIT;
               end
            end
         end
         S_PAD: begin
            state_next = S_EMIT;
         end
         S_EMIT: begin
            blk_valid = 1'b1;
            if (blk_ready) begin
               state_next = tail_reg ? S_TAIL : S_FILL;
            end
         end
         S_TAIL: begin
            state_next = S_EMIT;
         end
         default: begin
            state_next = S_FILL;
         end
      endcase
   end

   assign accept    = in_valid && in_ready;
   assign add_bits  = {(in_last ? clamp_nbytes(in_nbytes) : 3'd4), 3'b000};
   assign blk_data  = blk_reg;
   assign blk_first = blk_valid && first_reg;
   assign blk_last  = blk_valid && last_reg;

   // Emitted length is always 64 bits; a narrower counter is zero-extended.
   generate
      if (LEN_W >= 64) begin : g_len_trunc
         assign len64 = len_reg[63:0];
      end else begin : g_len_ext
         assign len64 = {{(64-LEN_W){1'b0}}, len_reg};
      end
   endgenerate

   assign len_words = len64;

   // ---------------- final-word padding ----------------
   sha_last_word_mask u_mask (
      .data   (blk_reg[widx_reg]),
      .nbytes (nbytes_reg),
      .masked (mask_word),
      .carry  (mask_carry)
   );

   // pad_pos is the word index holding 0x80; 16 means it spills into a tail block.
   assign widx_ext = {1'b0, widx_reg};
   assign pad_pos  = widx_ext + {4'b0000, mask_carry};
   assign len_fits = (pad_pos <= 5'd13);

   genvar gi;
   generate
      for (gi = 0; gi < 16; gi++) begin : g_pad
         sha_word_t body;
         assign body = (5'(gi) < widx_ext)                    ? blk_reg[gi] :
                       (5'(gi) == widx_ext)                   ? mask_word :
                       (mask_carry && (5'(gi) == pad_pos))    ? SHA_PAD_WORD : 32'h0;
         if (gi >= 14) begin : g_len
            assign pad_block[gi] = len_fits ? len_words[gi-14] : body;
         end else begin : g_body
            assign pad_block[gi] = body;
         end
      end
   endgenerate

   assign tail_block = {(pend_reg ? SHA_PAD_WORD : 32'h0), 416'h0, len64};

   // ---------------- datapath ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         blk_reg    <= '0;
         widx_reg   <= '0;
         len_reg    <= '0;
         nbytes_reg <= '0;
         first_reg  <= 1'b1;
         last_reg   <= 1'b0;
         tail_reg   <= 1'b0;
         pend_reg   <= 1'b0;
      end else begin
         case (state_reg)
            S_FILL: begin
               if (accept) begin
                  blk_reg[widx_reg] <= in_data;
                  len_reg           <= len_reg + LEN_W'(add_bits);
                  if (in_last) begin
                     nbytes_reg <= in_nbytes;
                  end else if (widx_reg == 4'd15) begin
                     last_reg <= 1'b0;
                     tail_reg <= 1'b0;
                  end else begin
                     widx_reg <= widx_reg + 4'd1;
                  end
               end
            end
            S_PAD: begin
               blk_reg  <= pad_block;
               last_reg <= len_fits;
               tail_reg <= !len_fits;
               pend_reg <= (pad_pos == 5'd16);
            end
            S_EMIT: begin
               if (blk_ready) begin
                  widx_reg <= '0;
                  if (last_reg) begin
                     len_reg   <= '0;
                     first_reg <= 1'b1;
                  end else begin
                     first_reg <= 1'b0;
                  end
               end
            end
            S_TAIL: begin
               blk_reg  <= tail_block;
               last_reg <= 1'b1;
               tail_reg <= 1'b0;
            end
            default: begin
            end
         endcase
      end
   end

`ifdef SHA_MSG_PADDER_ERRCHK_EN
   logic err_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         err_reg <= 1'b0;
      end else if (accept && in_last && (in_nbytes > 3'd4)) begin
         err_reg <= 1'b1;
      end
   end

   assign err = err_reg;
`endif

endmodule

// File: tb/tb_sha_msg_padder.sv
// Randomized and directed bench for sha_msg_padder against a byte-level SHA-256 padding model.
module tb_sha_msg_padder;
   import sha_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic       in_valid;
   logic       in_ready;
   logic [31:0] in_data;
   logic       in_last;
   logic [2:0] in_nbytes;
   logic       blk_valid;
   logic       blk_ready;
   sha_block_t blk_data;
   logic       blk_first;
   logic       blk_last;
`ifdef SHA_MSG_PADDER_ERRCHK_EN
   logic       err;
`endif

   sha_msg_padder #(.LEN_W(64)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .in_nbytes (in_nbytes),
      .blk_valid (blk_valid),
      .blk_ready (blk_ready),
      .blk_data  (blk_data),
      .blk_first (blk_first),
`ifdef SHA_MSG_PADDER_ERRCHK_EN
      .err       (err),
`endif
      .blk_last  (blk_last)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   logic err_exp = 1'b0;

   logic [31:0]  msg_words[$];
   int           msg_last_nb;
   logic [511:0] exp_blk[$];
   logic         exp_first[$];
   logic         exp_last[$];

   task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   function automatic void clear_exp();
      exp_blk.delete();
      exp_first.delete();
      exp_last.delete();
   endfunction

   function automatic void push_exp(input logic [511:0] v, input logic f, input logic l);
      exp_blk.push_back(v);
      exp_first.push_back(f);
      exp_last.push_back(l);
   endfunction

   // Message words from index 'from' laid out as a block, missing words zero.
   function automatic logic [511:0] words_blk(input int from);
      logic [511:0] v;
      v = '0;
      for (int i = 0; i < 16; i++) begin
         if (from + i < msg_words.size()) v[511-32*i -: 32] = msg_words[from+i];
      end
      return v;
   endfunction

   // Reference: flatten to bytes, append 0x80, zero-fill to 56 mod 64, append 64-bit bit length.
   function automatic void build_expected();
      logic [7:0]   b[$];
      logic [63:0]  bits;
      logic [31:0]  w;
      logic [511:0] v;
      int nb;
      int nblk;
      for (int i = 0; i < msg_words.size(); i++) begin
         nb = (i == msg_words.size() - 1) ? ((msg_last_nb > 4) ? 4 : msg_last_nb) : 4;
         w  = msg_words[i];
         for (int k = 0; k < nb; k++) b.push_back(w[31-8*k -: 8]);
      end
      bits = 64'(b.size()) * 64'd8;
      b.push_back(8'h80);
      while (b.size() % 64 != 56) b.push_back(8'h00);
      for (int k = 7; k >= 0; k--) b.push_back(bits[8*k +: 8]);
      nblk = b.size() / 64;
      for (int j = 0; j < nblk; j++) begin
         v = '0;
         for (int k = 0; k < 64; k++) v[511-8*k -: 8] = b[j*64+k];
         push_exp(v, (j == 0), (j == nblk - 1));
      end
   endfunction

   // Drives message words [from, to) with optional idle gaps; returns on the negedge after the last acceptance.
   task automatic drive_msg(input int gap_pct, input int from, input int to);
      int n;
      int guard;
      logic acc;
      n = msg_words.size();
      for (int i = from; i < to; i++) begin
         if (int'($urandom_range(99)) < gap_pct) begin
            in_valid = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
         end
         in_valid  = 1'b1;
         in_data   = msg_words[i];
         in_last   = (i == n - 1);
         in_nbytes = (i == n - 1) ? 3'(msg_last_nb) : 3'($urandom_range(7));
         guard = 0;
         forever begin
            acc = in_ready;
            @(negedge clk);
            if (acc) break;
            guard++;
            if (guard > 2000) begin
               check("drive_timeout", 1'b1, 1'b0);
               break;
            end
         end
         if (i == n - 1 && msg_last_nb > 4) err_exp = 1'b1;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic collect(input int ready_pct, input int hold0);
      int guard;
      int held;
      int idx;
      guard = 0;
      held  = 0;
      idx   = 0;
      while (exp_blk.size() > 0) begin
         blk_ready = (held >= hold0) && (int'($urandom_range(99)) < ready_pct);
         if (blk_valid) begin
            check($sformatf("blk%0d_data", idx), blk_data, exp_blk[0]);
            check($sformatf("blk%0d_first", idx), blk_first, exp_first[0]);
            check($sformatf("blk%0d_last", idx), blk_last, exp_last[0]);
            check($sformatf("blk%0d_in_ready", idx), in_ready, 1'b0);
            if (blk_ready) begin
               void'(exp_blk.pop_front());
               void'(exp_first.pop_front());
               void'(exp_last.pop_front());
               idx++;
            end else begin
               held++;
            end
         end
         @(negedge clk);
         guard++;
         if (guard > 5000) begin
            check("collect_timeout", 512'(exp_blk.size()), '0);
            clear_exp();
         end
      end
      blk_ready = 1'b0;
   endtask

   task automatic run_msg(input int gap_pct, input int ready_pct, input int hold0);
      fork
         drive_msg(gap_pct, 0, msg_words.size());
         collect(ready_pct, hold0);
      join
   endtask

   task automatic set_3byte();
      msg_words = {32'h87027900};
      msg_last_nb = 3;
      clear_exp();
      push_exp({32'h87027980, 448'h0, 32'h00000018}, 1'b1, 1'b1);
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      err_exp = 1'b0;
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_in_ready"}, in_ready, 1'b1);
      check({tag, "_blk_valid"}, blk_valid, 1'b0);
      check({tag, "_blk_first"}, blk_first, 1'b0);
      check({tag, "_blk_last"}, blk_last, 1'b0);
      check({tag, "_blk_data"}, blk_data, '0);
`ifdef SHA_MSG_PADDER_ERRCHK_EN
      check({tag, "_err"}, err, 1'b0);
`endif
   endtask

   task automatic check_err(input string tag);
`ifdef SHA_MSG_PADDER_ERRCHK_EN
      check({tag, "_err"}, err, err_exp);
`else
      if (tag.len() < 0) $display("%s", tag);
`endif
   endtask

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      in_last   = 1'b0;
      in_nbytes = '0;
      blk_ready = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      check_idle("rst");

      // 3-byte message, with final-block latency of two cycles
      set_3byte();
      drive_msg(0, 0, 1);
      check("lat_final_c1", blk_valid, 1'b0);
      @(negedge clk);
      check("lat_final_c2", blk_valid, 1'b1);
      collect(100, 0);

      // empty message
      msg_words = {32'($urandom)};
      msg_last_nb = 0;
      clear_exp();
      push_exp({32'h80000000, 480'h0}, 1'b1, 1'b1);
      run_msg(0, 100, 0);

      // 56 bytes: pad word lands in word 14, length goes to a tail block
      msg_words.delete();
      for (int i = 0; i < 14; i++) msg_words.push_back($urandom);
      msg_last_nb = 4;
      clear_exp();
      push_exp(words_blk(0) | {448'h0, 32'h80000000, 32'h0}, 1'b1, 1'b0);
      push_exp({480'h0, 32'h000001C0}, 1'b0, 1'b1);
      run_msg(30, 70, 0);

      // 64 bytes with the first block held off for 5 cycles
      msg_words.delete();
      for (int i = 0; i < 16; i++) msg_words.push_back($urandom);
      msg_last_nb = 4;
      clear_exp();
      push_exp(words_blk(0), 1'b1, 1'b0);
      push_exp({32'h80000000, 448'h0, 32'h00000200}, 1'b0, 1'b1);
      run_msg(0, 100, 5);

      // 20-word message: full non-final block appears one cycle after word 15
      msg_words.delete();
      for (int i = 0; i < 20; i++) msg_words.push_back($urandom);
      msg_last_nb = $urandom_range(0, 4);
      clear_exp();
      build_expected();
      drive_msg(0, 0, 16);
      check("lat_full_c1", blk_valid, 1'b1);
      fork
         drive_msg(20, 16, 20);
         collect(60, 5);
      join

      // oversize in_nbytes on the last word is padded as 4 bytes
      msg_words = {32'($urandom)};
      msg_last_nb = 6;
      clear_exp();
      push_exp(words_blk(0) | {32'h0, 32'h80000000, 416'h0, 32'h00000020}, 1'b1, 1'b1);
      run_msg(0, 100, 0);
      check_err("nb6");
      set_3byte();
      run_msg(0, 100, 0);
      check_err("nb6_sticky");

      // reset in the middle of filling
      msg_words.delete();
      for (int i = 0; i < 10; i++) msg_words.push_back($urandom);
      msg_last_nb = 4;
      drive_msg(0, 0, 5);
      pulse_reset();
      check_idle("rst_fill");
      set_3byte();
      run_msg(0, 100, 0);

      // reset while a block is waiting for the consumer
      msg_words.delete();
      for (int i = 0; i < 16; i++) msg_words.push_back($urandom);
      msg_last_nb = 4;
      drive_msg(0, 0, 16);
      @(negedge clk);
      check("rst_pend_valid_before", blk_valid, 1'b1);
      pulse_reset();
      check("rst_pend_valid_after", blk_valid, 1'b0);
      check("rst_pend_in_ready", in_ready, 1'b1);
      set_3byte();
      run_msg(0, 100, 0);

      // randomized messages against the byte-level model
      for (int m = 0; m < 25; m++) begin
         msg_words.delete();
         for (int i = 0; i < int'($urandom_range(1, 40)); i++) msg_words.push_back($urandom);
         msg_last_nb = ($urandom_range(7) == 0) ? int'($urandom_range(5, 7)) : int'($urandom_range(0, 4));
         clear_exp();
         build_expected();
         run_msg(25, 70, 0);
         check_err($sformatf("rand%0d", m));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sha_msg_padder.md
Name: sha_msg_padder

Overview:
- Upstream stage of the SHA-256 compression core. Accepts a message as a stream of 32-bit big-endian words.
- Applies SHA-256 padding: a 0x80 byte, zero fill, and a 64-bit bit-length.
- Emits complete 512-bit blocks as 16 x 32-bit words, in the same format the hash core consumes on its W input.
- Uses a valid/ready handshake on both sides.

Parameters:
- LEN_W, 64: width of the internal bit-length counter. Bits above LEN_W-1 in the emitted length are zero. The counter wraps modulo 2^LEN_W.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  input word valid
- in_ready  out  1  padder can accept a word
- in_data  in  32  message word; byte 0 is in [31:24]
- in_last  in  1  this is the final word of the message
- in_nbytes  in  3  valid bytes in the word (0..4). Meaningful only when in_last=1; non-last words are always treated as 4 bytes.
- blk_valid  out  1  output block valid
- blk_ready  in  1  consumer accepts the block
- blk_data  out  16x32  block, packed [0:15][31:0]; word 0 is first
- blk_first  out  1  block is the first of its message
- blk_last  out  1  block is the final block of its message

Behaviour:
- Reset values: all outputs 0 except in_ready=1. Buffer cleared, word index widx=0, byte count 0, first flag=1.
- Reset asserted mid-operation discards the partial or pending block. blk_valid drops on the next edge. The next message starts fresh with blk_first=1.
- States:
  - S_FILL: in_ready=1. A word is accepted when in_valid&&in_ready. It is written to buf[widx] and the byte count increases by 4, or by in_nbytes if in_last.
    - Non-last word at widx=15 goes to S_EMIT with blk_last=0.
    - Last word goes to S_PAD.
  - S_PAD: one cycle, in_ready=0. Uses the last-word mask. Bytes at and beyond in_nbytes are zeroed, and 0x80 is placed at byte position in_nbytes.
    - If in_nbytes=4, the 0x80 goes to word widx+1 as 0x80000000.
    - Let p be the index of the word holding 0x80. Words after p are zeroed.
    - If p<=13: words 14/15 = {len[63:32], len[31:0]} with len = bytes*8. Then S_EMIT with blk_last=1.
    - If p=14 or 15: emit without length (blk_last=0), then S_TAIL with pad_pending=0.
    - If p=16 (last word at index 15 with 4 bytes): emit the data block, then S_TAIL with pad_pending=1.
  - S_EMIT: blk_valid=1 and in_ready=0. blk_data, blk_first and blk_last are held stable until blk_ready.
    - On handshake: blk_first is cleared and widx=0.
    - Next state is S_TAIL if a tail is owed, else S_FILL.
    - If the block had blk_last=1, also clear the byte count and set first=1.
  - S_TAIL: one cycle. Build a block of zeros, with word0=0x80000000 if pad_pending, and words 14/15 = length. Then S_EMIT with blk_last=1.
- Latency:
  - A full non-final block: blk_valid rises 1 cycle after word 15 is accepted.
  - The final block: blk_valid rises 2 cycles after the last word is accepted.
- in_nbytes>4 on a last word is treated as 4.
- A message of zero bytes is in_last with in_nbytes=0 on a single word.
- Length word ordering is big-endian: word14 is the upper half, word15 the lower half.

Optional Feature:
- Macro: SHA_MSG_PADDER_ERRCHK_EN.
- Defined:
  - Adds output port err (1 bit), sticky, cleared only by reset.
  - err is set on an accepted word with in_last=1 and in_nbytes>4.
  - The word is still processed as 4 bytes.
- Undefined: port absent, no check logic.

Decomposition:
- Shared package sha_pkg:
  - sha_word_t (logic [31:0]) and sha_block_t (logic [0:15][31:0])
  - SHA_PAD_BYTE=8'h80
  - padder state enum (S_FILL, S_PAD, S_EMIT, S_TAIL)
- One sub-module: sha_last_word_mask. Combinational: in_data + nbytes -> masked word with 0x80 inserted, plus a carry flag when nbytes=4.

Test Plan:
- 3-byte message: word 0x87027900, last, nbytes=3 -> one block. w0=0x87027980, w1..w14=0, w15=0x00000018, first=last=1.
- Empty message: word last, nbytes=0 -> w0=0x80000000, w1..w15=0, first=last=1.
- 56 bytes (14 words, last nbytes=4):
  - Block1: data w0..13, w14=0x80000000, w15=0, last=0.
  - Block2: zeros with w15=0x000001C0, first=0, last=1.
- 64 bytes (16 words, last nbytes=4):
  - Block1: 16 data words, last=0.
  - Block2: w0=0x80000000, w14=0, w15=0x00000200, last=1.
- Backpressure and reset:
  - Hold blk_ready=0 for 5 cycles -> blk_data stable, in_ready=0, no input consumed.
  - Assert reset mid-fill -> blk_valid=0. The next 3-byte message yields the same block as the first scenario (length 0x18).
- With SHA_MSG_PADDER_ERRCHK_EN: last word nbytes=6 -> err=1 and stays 1. The block is padded as for 4 bytes.
